// File: rtl/ml_alert_debouncer.sv
// rtl/ml_alert_debouncer.sv - persistence filter, hold and cooldown for ML classifier alerts
module ml_alert_debouncer #(
  parameter int PERSIST  = 3,
  parameter int CONF_MIN = 16,
  parameter int HOLD_CYC = 1024,
  parameter int COOL_CYC = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] ml_class,
  input  logic [7:0] ml_confidence,
  input  logic       ml_valid,
  input  logic       alert_ack,
  output logic       alert_active,
  output logic       alert_pulse,
  output logic [2:0] alert_class,
  output logic [7:0] alert_peak,
  output logic [7:0] alert_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMING = 2'd1,
    S_ALERT  = 2'd2,
    S_COOL   = 2'd3
  } state_t;

  localparam logic [7:0]  CONF_MIN_L = 8'(CONF_MIN);
  localparam logic [3:0]  PERSIST_L  = 4'(PERSIST);
  localparam logic [15:0] HOLD_L     = 16'(HOLD_CYC);
  localparam logic [15:0] COOL_L     = 16'(COOL_CYC);

  state_t      state, state_next;
  logic [2:0]  cand, cand_next;
  logic [3:0]  streak, streak_next;
  logic [7:0]  peak, peak_next;
  logic [15:0] hold, hold_next;
  logic [15:0] cool, cool_next;

  logic       active_next, pulse_next;
  logic [2:0] class_next;
  logic [7:0] apeak_next, count_next;

  logic       qual;
  logic       same_cls;
  logic [3:0] streak_inc;
  logic [7:0] peak_max;

  // Class 6/7 count as anomalies: any non-zero class with enough confidence qualifies.
  assign qual       = ml_valid & (ml_class != 3'd0) & (ml_confidence >= CONF_MIN_L);
  assign same_cls   = (ml_class == cand);
  assign streak_inc = streak + 4'd1;
  assign peak_max   = (ml_confidence > peak) ? ml_confidence : peak;

  // State and internal counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cand   <= 3'd0;
      streak <= 4'd0;
      peak   <= 8'd0;
      hold   <= 16'd0;
      cool   <= 16'd0;
    end else begin
      state  <= state_next;
      cand   <= cand_next;
      streak <= streak_next;
      peak   <= peak_next;
      hold   <= hold_next;
      cool   <= cool_next;
    end
  end

  // Next state: streak qualification, retriggerable hold, fixed cooldown.
  always_comb begin
    state_next  = state;
    cand_next   = cand;
    streak_next = streak;
    peak_next   = peak;
    hold_next   = hold;
    cool_next   = cool;
    case (state)
      S_IDLE: begin
        if (qual) begin
          state_next  = S_ARMING;
          cand_next   = ml_class;
          streak_next = 4'd1;
          peak_next   = ml_confidence;
        end
      end
      S_ARMING: begin
        if (ml_valid && !qual) begin
          state_next  = S_IDLE;
          streak_next = 4'd0;
        end else if (qual && !same_cls) begin
          cand_next   = ml_class;
          streak_next = 4'd1;
          peak_next   = ml_confidence;
        end else if (qual) begin
          peak_next = peak_max;
          if (streak_inc == PERSIST_L) begin
            state_next  = S_ALERT;
            streak_next = 4'd0;
            hold_next   = HOLD_L;
          end else begin
            streak_next = streak_inc;
          end
        end
      end
      S_ALERT: begin
        // Ack beats a same-cycle retrigger; a retrigger beats expiry.
        if (alert_ack) begin
          state_next = S_COOL;
          hold_next  = 16'd0;
          cool_next  = COOL_L;
        end else if (qual && same_cls) begin
          hold_next = HOLD_L;
          peak_next = peak_max;
        end else if (hold == 16'd1) begin
          state_next = S_COOL;
          hold_next  = 16'd0;
          cool_next  = COOL_L;
        end else begin
          hold_next = hold - 16'd1;
        end
      end
      S_COOL: begin
        if (cool == 16'd1) begin
          state_next  = S_IDLE;
          cool_next   = 16'd0;
          streak_next = 4'd0;
        end else begin
          cool_next = cool - 16'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output values for the next cycle; class/peak only follow the FSM while alerting.
  always_comb begin
    active_next = (state_next == S_ALERT);
    pulse_next  = (state_next == S_ALERT) && (state != S_ALERT);
    class_next  = alert_class;
    apeak_next  = alert_peak;
    count_next  = alert_count;
    if (state_next == S_ALERT) begin
      class_next = cand_next;
      apeak_next = peak_next;
    end
    if (pulse_next && (alert_count != 8'hFF)) begin
      count_next = alert_count + 8'd1;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alert_active <= 1'b0;
      alert_pulse  <= 1'b0;
      alert_class  <= 3'd0;
      alert_peak   <= 8'd0;
      alert_count  <= 8'd0;
    end else begin
      alert_active <= active_next;
      alert_pulse  <= pulse_next;
      alert_class  <= class_next;
      alert_peak   <= apeak_next;
      alert_count  <= count_next;
    end
  end

endmodule
